draw_addr_gen: RTL and testbench
================================

# draw_addr_gen

Parametrised multi-lane address sweep generator for the draw datapath. On a start pulse it walks a run-time-programmed word range, presenting one address per lane per accepted beat; lane k's address is the word index with the lane number appended as the low bits, so the lanes interleave into one memory. It supports downstream stall, abort, and a continuous loop mode, and signals completion with a one-cycle done pulse.

## Interface
Parameters:
- ADDR_W, 14, full address width per lane
- LANES, 2, lane count; power of two, ≥2
- LB, $clog2(LANES), derived lane-index width
- WORD_W, ADDR_W-LB, derived word-index width

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high; one clock, all state cleared on the edge where reset=1
- start  in  1  begin a sweep; honoured only in IDLE
- base  in  WORD_W  first word index, sampled on accepted start
- length  in  WORD_W+1  words per sweep, sampled on accepted start
- loop  in  1  sampled on accepted start; 1 = repeat the sweep until aborted
- abort  in  1  terminate the sweep without done
- stall  in  1  downstream not ready; hold the current beat
- addr  out  LANES*ADDR_W  lane k at bits [k*ADDR_W +: ADDR_W] = {word, k[LB-1:0]}
- valid  out  1  addr holds a live beat
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse when a non-loop sweep completes

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1: latch base, length and loop into base_l, len_l and loop_l. If length=0, go to DONE. Otherwise load word=base and remaining=length, then go to RUN.
- RUN: valid=1. The beat is accepted when stall=0.
  - Accepted, remaining>1: word<=word+1 (mod 2^WORD_W), remaining<=remaining-1.
  - Accepted, remaining=1, loop_l=1: word<=base_l, remaining<=len_l.
  - Accepted, remaining=1, loop_l=0: go to DONE.
  - stall=1: word, remaining and addr hold.
- RUN, abort=1: go to IDLE. Abort takes priority over stall and over beat completion. done does not assert.
- DONE: done=1 for exactly one cycle, then go to IDLE. start is ignored in DONE.
- start while busy is ignored. base, length and loop may change freely after an accepted start.
- Word arithmetic wraps modulo 2^WORD_W. No saturation and no error flag.
- Reset mid-sweep: the next cycle is IDLE with all outputs at reset values. No done.

## Timing
- Reset values: addr=0, valid=0, busy=0, done=0, state=IDLE.
- All outputs are registered. There are no combinational input-to-output paths.
- start accepted at edge n: valid=1 and addr=base from cycle n+1, busy=1 from n+1.
- Throughput is one beat per cycle with stall=0.
- Last beat accepted at edge m: valid=0 and done=1 in cycle m+1, busy=0 from m+2.
- length=0: done=1 in cycle n+1, valid never asserts.
- abort seen at edge a: valid=0 and busy=0 from cycle a+1.

## Structure
- Shared package draw_pkg holds:
  - the draw_state_t enum {IDLE, RUN, DONE}
  - default localparams DRAW_ADDR_W=14 and DRAW_LANES=2
- One sub-module, draw_word_counter: a loadable WORD_W word counter with a WORD_W+1 remaining counter.
  - Inputs: load, advance, reload.
  - Outputs: word, last (remaining=1).
- Lane packing is a generate loop in the top level.

## Test plan
- Default params, base=2816, length=128, stall=0 → 128 consecutive beats. First beat lane0=5632, lane1=5633. Last beat 5886/5887. done pulses one cycle after the last beat, and busy falls the cycle after that.
- Same sweep with stall toggling every cycle → identical 128-beat sequence over about 256 cycles. addr is stable while stalled. Single done.
- loop=1, base=10, length=3 → words 10,11,12,10,11,12,… with no done. abort → valid=0 and busy=0 next cycle, still no done.
- base=8190, length=4 (WORD_W=13) → words 8190, 8191, 0, 1 (lane0 addresses 16380, 16382, 0, 2), then done.
- length=0 → done one cycle after start, valid never high. A start pulse during a running sweep has no effect on the sequence.
- LANES=4, ADDR_W=16, base=5, length=2 → beat 1 lanes 20/21/22/23, beat 2 lanes 24/25/26/27. reset asserted on beat 2 → all outputs 0 next cycle, no done.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared types and defaults for the draw address path.
package draw_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} draw_state_t;

  localparam int DRAW_ADDR_W = 14;
  localparam int DRAW_LANES  = 2;
endpackage

// File: rtl/draw_addr_gen_if.sv
// Command/beat bundle between a sweep requester (master) and draw_addr_gen (slave).
interface draw_addr_gen_if
  import draw_pkg::*;
#(
  parameter int ADDR_W = DRAW_ADDR_W,
  parameter int LANES  = DRAW_LANES,
  parameter int LB     = $clog2(LANES),
  parameter int WORD_W = ADDR_W - LB
);
  logic                    start;
  logic [WORD_W-1:0]       base;
  logic [WORD_W:0]         length;
  logic                    loop;
  logic                    abort;
  logic                    stall;
  logic [LANES*ADDR_W-1:0] addr;
  logic                    valid;
  logic                    busy;
  logic                    done;

  modport master (output start, base, length, loop, abort, stall,
                  input  addr, valid, busy, done);
  modport slave  (input  start, base, length, loop, abort, stall,
                  output addr, valid, busy, done);
endinterface

// File: rtl/draw_word_counter.sv
// Loadable word counter with a remaining-beats count; reload restarts the latched range.
module draw_word_counter
  import draw_pkg::*;
#(
  parameter int WORD_W = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic              reload,
  input  logic [WORD_W-1:0] base,
  input  logic [WORD_W:0]   length,
  output logic [WORD_W-1:0] word,
  output logic              last
);
  logic [WORD_W-1:0] base_l;
  logic [WORD_W:0]   len_l;
  logic [WORD_W:0]   remaining;

  always_ff @(posedge clk) begin
    if (reset) begin
      base_l    <= '0;
      len_l     <= '0;
      word      <= '0;
      remaining <= '0;
    end else if (load) begin
      base_l    <= base;
      len_l     <= length;
      word      <= base;
      remaining <= length;
    end else if (reload) begin
      word      <= base_l;
      remaining <= len_l;
    end else if (advance) begin
      // word wraps naturally at 2^WORD_W
      word      <= word + WORD_W'(1);
      remaining <= remaining - (WORD_W+1)'(1);
    end
  end

  assign last = (remaining == (WORD_W+1)'(1));
endmodule

// File: rtl/draw_addr_gen.sv
// Multi-lane address sweep: one word per beat, lane index appended as address LSBs.
module draw_addr_gen
  import draw_pkg::*;
#(
  parameter int ADDR_W = DRAW_ADDR_W,
  parameter int LANES  = DRAW_LANES,
  parameter int LB     = $clog2(LANES),
  parameter int WORD_W = ADDR_W - LB
) (
  input  logic          clk,
  input  logic          reset,
  draw_addr_gen_if.slave bus
);
  draw_state_t       state, state_nx;
  logic              loop_l;
  logic [WORD_W-1:0] word;
  logic              last;
  logic              load, accept, advance, reload;
  logic              vld, bsy, dn;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      loop_l <= 1'b0;
    end else begin
      state <= state_nx;
      if (load) loop_l <= bus.loop;
    end
  end

  // abort wins over stall and over completion of the final beat
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = (bus.length == '0) ? DONE : RUN;
      RUN:     if (bus.abort) state_nx = IDLE;
               else if (!bus.stall && last && !loop_l) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    vld = 1'b0;
    bsy = 1'b0;
    dn  = 1'b0;
    case (state)
      RUN:     begin vld = 1'b1; bsy = 1'b1; end
      DONE:    begin bsy = 1'b1; dn = 1'b1; end
      default: ;
    endcase
  end

  assign load    = (state == IDLE) && bus.start;
  assign accept  = (state == RUN) && !bus.stall && !bus.abort;
  assign advance = accept && !last;
  assign reload  = accept && last && loop_l;

  draw_word_counter #(.WORD_W(WORD_W)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .advance(advance),
    .reload (reload),
    .base   (bus.base),
    .length (bus.length),
    .word   (word),
    .last   (last)
  );

  // addr reads as zero whenever no beat is live
  logic [LANES-1:0][ADDR_W-1:0] lane_addr;
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane_addr[k] = vld ? {word, LB'(k)} : '0;
  end

  assign bus.addr  = lane_addr;
  assign bus.valid = vld;
  assign bus.busy  = bsy;
  assign bus.done  = dn;
endmodule

// File: tb/tb_draw_addr_gen.sv
// Randomized sweep checks against a queue-free arithmetic model of the word sequence.
module tb_draw_addr_gen;
  localparam int AW_A = 14, LN_A = 2, WW_A = 13;
  localparam int AW_B = 16, LN_B = 4;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  draw_addr_gen_if #(.ADDR_W(AW_A), .LANES(LN_A)) ia ();
  draw_addr_gen_if #(.ADDR_W(AW_B), .LANES(LN_B)) ib ();

  draw_addr_gen #(.ADDR_W(AW_A), .LANES(LN_A)) ua (.clk(clk), .reset(rst_a), .bus(ia));
  draw_addr_gen #(.ADDR_W(AW_B), .LANES(LN_B)) ub (.clk(clk), .reset(rst_b), .bus(ib));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // smode: 0 no stall, 1 stall every other cycle, 2 random stall.
  // Loop sweeps are aborted once nbeats beats have been accepted.
  task automatic sweep(input int b, input int len, input bit lp, input int smode, input int nbeats);
    int i, cyc, total;
    total = lp ? nbeats : len;
    ia.base = WW_A'(b); ia.length = (WW_A+1)'(len); ia.loop = lp; ia.start = 1'b1;
    step;
    ia.start = 1'b0;
    ia.base = WW_A'($urandom); ia.length = (WW_A+1)'($urandom); ia.loop = 1'($urandom);
    chk("busy_after_start", ia.busy, 1);
    if (len == 0) begin
      chk("len0_valid", ia.valid, 0);
      chk("len0_done", ia.done, 1);
      step;
      chk("len0_done_drop", ia.done, 0);
      chk("len0_busy_drop", ia.busy, 0);
      chk("len0_valid_idle", ia.valid, 0);
      return;
    end
    i = 0; cyc = 0;
    while (i < total && cyc < 4000) begin
      chk("run_valid", ia.valid, 1);
      chk("run_busy", ia.busy, 1);
      chk("run_done", ia.done, 0);
      for (int k = 0; k < LN_A; k++)
        chk("lane_addr", ia.addr[k*AW_A +: AW_A], ((b + i % len) % (1 << WW_A)) * LN_A + k);
      case (smode)
        0:       ia.stall = 1'b0;
        1:       ia.stall = (cyc % 2 == 0);
        default: ia.stall = 1'($urandom_range(0, 1));
      endcase
      ia.start = (cyc == 3);  // must be ignored while busy
      if (!ia.stall) i++;
      cyc++;
      step;
    end
    ia.start = 1'b0;
    chk("beats_accepted", i, total);
    if (lp) begin
      chk("loop_no_done", ia.done, 0);
      chk("loop_still_valid", ia.valid, 1);
      ia.abort = 1'b1;
      ia.stall = 1'($urandom_range(0, 1));
      step;
      ia.abort = 1'b0; ia.stall = 1'b0;
      chk("abort_valid", ia.valid, 0);
      chk("abort_busy", ia.busy, 0);
      chk("abort_done", ia.done, 0);
      chk("abort_addr", ia.addr, 0);
      step;
      chk("abort_no_done_later", ia.done, 0);
      chk("abort_stays_idle", ia.busy, 0);
    end else begin
      chk("end_valid", ia.valid, 0);
      chk("end_done", ia.done, 1);
      chk("end_busy", ia.busy, 1);
      ia.start = 1'b1; ia.length = 5;  // start during DONE is ignored
      step;
      ia.start = 1'b0;
      chk("done_pulse_width", ia.done, 0);
      chk("busy_fall", ia.busy, 0);
      chk("idle_valid", ia.valid, 0);
    end
  endtask

  initial begin
    ia.start = 0; ia.base = 0; ia.length = 0; ia.loop = 0; ia.abort = 0; ia.stall = 0;
    ib.start = 0; ib.base = 0; ib.length = 0; ib.loop = 0; ib.abort = 0; ib.stall = 0;
    rst_a = 1'b1; rst_b = 1'b1;
    ia.base = 17; ia.length = 3; ia.start = 1'b1;  // start under reset must not register
    step; step;
    ia.start = 1'b0;
    chk("rst_addr", ia.addr, 0);
    chk("rst_valid", ia.valid, 0);
    chk("rst_busy", ia.busy, 0);
    chk("rst_done", ia.done, 0);
    chk("rstb_addr", ib.addr, 0);
    chk("rstb_valid", ib.valid, 0);
    rst_a = 1'b0; rst_b = 1'b0;
    step;
    chk("post_rst_idle", ia.busy, 0);

    sweep(2816, 128, 1'b0, 0, 0);
    sweep(2816, 128, 1'b0, 1, 0);
    sweep(10, 3, 1'b1, 0, 8);
    sweep(8190, 4, 1'b0, 0, 0);
    sweep(0, 0, 1'b0, 0, 0);
    sweep(8191, 1, 1'b0, 2, 0);
    sweep(8191, 1, 1'b1, 2, 5);
    for (int r = 0; r < 8; r++) begin
      int b = (r % 2) ? int'($urandom_range(8180, 8191)) : int'($urandom_range(0, 8191));
      sweep(b, $urandom_range(1, 12), 1'($urandom), 2, $urandom_range(1, 20));
    end

    // four lanes, reset in the middle of the sweep
    ib.base = 5; ib.length = 2; ib.loop = 0; ib.start = 1'b1;
    step;
    ib.start = 1'b0;
    for (int k = 0; k < LN_B; k++) chk("b_beat1", ib.addr[k*AW_B +: AW_B], 20 + k);
    chk("b_beat1_valid", ib.valid, 1);
    step;
    for (int k = 0; k < LN_B; k++) chk("b_beat2", ib.addr[k*AW_B +: AW_B], 24 + k);
    rst_b = 1'b1;
    step;
    rst_b = 1'b0;
    chk("b_rst_addr", ib.addr, 0);
    chk("b_rst_valid", ib.valid, 0);
    chk("b_rst_busy", ib.busy, 0);
    chk("b_rst_done", ib.done, 0);
    step;
    chk("b_rst_no_done", ib.done, 0);
    chk("b_rst_idle", ib.busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
